note_lane: RTL and testbench

//  One arrow lane of the DDR game: consumes the pseudo-random press bit from the upstream

---
 rtl/ddr_pkg.sv | 8 +
 rtl/tick_divider.sv | 17 +
 rtl/note_lane.sv | 51 +++++
 tb/tb_note_lane.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// ddr_pkg: board defaults shared by the DDR game lanes and display logic.
package ddr_pkg;
    localparam int LANE_ROWS = 8;
    localparam int TICK_DIV  = 4;
    localparam int SCORE_W   = 8;
    localparam int NUM_LANES = 4;
    typedef enum logic [1:0] {EV_NONE, EV_HIT, EV_MISS} lane_ev_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: emits a one-cycle step every DIV enabled cycles; count holds while disabled.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic enable,
    output logic step
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] count;
    assign step = enable && count == CW'(DIV - 1);
    always_ff @(posedge Clock) begin
        if (Reset) count <= '0;
        else if (enable) count <= step ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/note_lane.sv
// note_lane: one arrow lane; spawns and scrolls notes, scores key presses against the bottom row.
module note_lane #(
    parameter int ROWS     = ddr_pkg::LANE_ROWS,
    parameter int TICK_DIV = ddr_pkg::TICK_DIV,
    parameter int SCORE_W  = ddr_pkg::SCORE_W
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               press,
    input  logic               key,
    input  logic               enable,
    output logic [ROWS-1:0]    column,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score
);
    import ddr_pkg::*;
    logic step, key_q, key_rise, bot;
    logic [ROWS-1:0] kept;
    lane_ev_t ev;
    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .Clock (Clock),
        .Reset (Reset),
        .enable(enable),
        .step  (step)
    );
    assign key_rise = key & ~key_q;
    assign bot = column[ROWS-1];
    // A key press always takes priority over a note falling off on the same step.
    always_comb begin
        ev = !enable ? EV_NONE : key_rise ? (bot ? EV_HIT : EV_MISS) : (step && bot) ? EV_MISS : EV_NONE;
        kept = (ev == EV_HIT) ? {1'b0, column[ROWS-2:0]} : column;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            column <= '0;
            score <= '0;
            hit <= 1'b0;
            miss <= 1'b0;
            key_q <= 1'b1;
        end else begin
            key_q <= key;
            hit <= ev == EV_HIT;
            miss <= ev == EV_MISS;
            if (enable) begin
                column <= step ? {kept[ROWS-2:0], press} : kept;
                if (ev == EV_HIT && score != '1) score <= score + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_note_lane.sv
// tb_note_lane: scenario tasks push expected lane state per cycle and compare against the lane.
module tb_note_lane;
    typedef struct packed {
        logic [3:0] col;
        logic       hit;
        logic       miss;
        logic [7:0] score;
    } obs_t;
    logic Clock = 1'b0, Reset = 1'b0, press = 1'b0, key = 1'b0, enable = 1'b0;
    logic [3:0] column, column2;
    logic hit, miss, hit2, miss2;
    logic [7:0] score;
    logic [1:0] score2;
    obs_t sb[$];
    obs_t e, g;
    int checks = 0, failures = 0;

    always #5 Clock = ~Clock;

    note_lane #(.ROWS(4), .TICK_DIV(4), .SCORE_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .press(press), .key(key), .enable(enable),
        .column(column), .hit(hit), .miss(miss), .score(score)
    );
    note_lane #(.ROWS(4), .TICK_DIV(4), .SCORE_W(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .press(press), .key(key), .enable(enable),
        .column(column2), .hit(hit2), .miss(miss2), .score(score2)
    );

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) cyc();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        key = 1'b1; press = 1'b1; enable = 1'b1;
        do_reset(2);
        checks++;
        if ({column, hit, miss, score} !== 14'h0) begin
            failures++;
            $display("FAIL reset got=%h exp=0", {column, hit, miss, score});
        end
        checks++;
        if ({column2, hit2, miss2, score2} !== 8'h0) begin
            failures++;
            $display("FAIL reset_w2 got=%h exp=0", {column2, hit2, miss2, score2});
        end
    endtask

    task automatic test_fill();
        enable = 1'b1; press = 1'b1; key = 1'b0;
        do_reset(2);
        for (int k = 1; k <= 24; k++) begin
            e.col = k < 4 ? 4'h0 : k < 8 ? 4'h1 : k < 12 ? 4'h3 : k < 16 ? 4'h7 : 4'hf;
            e.hit = 1'b0;
            e.miss = k >= 20 && k % 4 == 0;
            e.score = 8'd0;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            g = {column, hit, miss, score};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL fill k=%0d got=%h exp=%h", k, g, e);
            end
        end
    endtask

    task automatic test_hit();
        enable = 1'b1; key = 1'b0;
        do_reset(2);
        for (int k = 1; k <= 22; k++) begin
            press = k <= 4;
            key = k >= 18;
            e.col = k < 4 ? 4'h0 : k < 8 ? 4'h1 : k < 12 ? 4'h2 : k < 16 ? 4'h4 : k < 18 ? 4'h8 : 4'h0;
            e.hit = k == 18;
            e.miss = 1'b0;
            e.score = k >= 18 ? 8'd1 : 8'd0;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            g = {column, hit, miss, score};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL hit k=%0d got=%h exp=%h", k, g, e);
            end
        end
        key = 1'b0;
    endtask

    task automatic test_false_press();
        enable = 1'b1; press = 1'b0; key = 1'b0;
        do_reset(2);
        for (int k = 1; k <= 10; k++) begin
            key = k >= 2;
            e.col = 4'h0;
            e.hit = 1'b0;
            e.miss = k == 2;
            e.score = 8'd0;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            g = {column, hit, miss, score};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL false_press k=%0d got=%h exp=%h", k, g, e);
            end
        end
        key = 1'b0;
    endtask

    task automatic test_step_hit();
        enable = 1'b1; key = 1'b0;
        do_reset(2);
        for (int k = 1; k <= 24; k++) begin
            press = k <= 8;
            key = k >= 20;
            e.col = k < 4 ? 4'h0 : k < 8 ? 4'h1 : k < 12 ? 4'h3 : k < 16 ? 4'h6 : k < 20 ? 4'hc : k < 24 ? 4'h8 : 4'h0;
            e.hit = k == 20;
            e.miss = k == 24;
            e.score = k >= 20 ? 8'd1 : 8'd0;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            g = {column, hit, miss, score};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL step_hit k=%0d got=%h exp=%h", k, g, e);
            end
        end
        key = 1'b0;
    endtask

    task automatic test_saturate();
        enable = 1'b1; press = 1'b1; key = 1'b0;
        do_reset(2);
        for (int k = 1; k <= 36; k++) begin
            key = k % 4 == 2 && k >= 18 && k <= 34;
            e.col = k < 4 ? 4'h0 : k < 8 ? 4'h1 : k < 12 ? 4'h3 : k < 16 ? 4'h7 :
                    (k % 4 >= 2 && k <= 35) ? 4'h7 : 4'hf;
            e.hit = key;
            e.miss = 1'b0;
            e.score = k < 18 ? 8'd0 : k < 22 ? 8'd1 : k < 26 ? 8'd2 : 8'd3;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            g = {column2, hit2, miss2, 6'b0, score2};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL saturate k=%0d got=%h exp=%h", k, g, e);
            end
        end
        key = 1'b0;
    endtask

    task automatic test_reset_freeze();
        enable = 1'b1; press = 1'b1; key = 1'b1;
        do_reset(2);
        repeat (10) cyc();
        Reset = 1'b1;
        e = '0;
        sb.push_back(e);
        cyc();
        Reset = 1'b0;
        e = sb.pop_front();
        g = {column, hit, miss, score};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", g, e);
        end
        for (int j = 1; j <= 25; j++) begin
            enable = !(j >= 11 && j <= 20);
            key = !(j >= 13 && j <= 14);
            e.col = j < 4 ? 4'h0 : j < 8 ? 4'h1 : j < 22 ? 4'h3 : 4'h7;
            e.hit = 1'b0;
            e.miss = 1'b0;
            e.score = 8'd0;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            g = {column, hit, miss, score};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL freeze j=%0d got=%h exp=%h", j, g, e);
            end
        end
        key = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hit();
        test_false_press();
        test_step_hit();
        test_saturate();
        test_reset_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
